// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake bundle: instruction-memory request/response, decode
// presentation and redirect/halt controls.
interface pc_sequencer_if;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;

  logic               im_req;
  logic [ADDR_W-1:0]  im_addr;
  logic               im_ack;
  logic [INSTR_W-1:0] im_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  instr_pc;
  logic               dec_ready;
  logic               br_valid;
  logic [ADDR_W-1:0]  br_target;
  logic               halt_req;

  modport master (
    output im_req, im_addr, instr, instr_valid, instr_pc,
    input  im_ack, im_rdata, dec_ready, br_valid, br_target, halt_req
  );

  modport slave (
    input  im_req, im_addr, instr, instr_valid, instr_pc,
    output im_ack, im_rdata, dec_ready, br_valid, br_target, halt_req
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, issues instruction-memory fetches, holds each
// word for decode, and applies redirects, halts and misaligned-target faults.
module pc_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_sequencer_if.master       bus,
  output logic [63:0]          pc,
  output logic                 halted,
  output logic                 fault
);
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               im_req_q, im_req_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic               pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]  pend_target_q, pend_target_d;
  logic [ADDR_W-1:0]  tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      im_req_q      <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      im_req_q      <= im_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    im_req_d      = im_req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    tgt           = bus.br_valid ? bus.br_target : pend_target_q;

    case (state_q)
      BOOT: begin
        state_d  = FETCH;
        im_req_d = 1'b1;
      end
      FETCH: begin
        if (bus.im_ack) begin
          if (bus.br_valid || pend_valid_q) begin
            // Redirected fetch: drop the returned word and refetch at the target
            pend_valid_d = 1'b0;
            if (tgt[1:0] != 2'b00) begin
              fault_d  = 1'b1;
              halted_d = 1'b1;
              im_req_d = 1'b0;
              state_d  = HALT;
            end else begin
              pc_d = tgt;
            end
          end else begin
            instr_d       = bus.im_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            im_req_d      = 1'b0;
            state_d       = ISSUE;
          end
        end else if (bus.br_valid) begin
          pend_valid_d  = 1'b1;
          pend_target_d = bus.br_target;
        end
      end
      ISSUE: begin
        if (bus.br_valid) begin
          instr_valid_d = 1'b0;
          if (bus.br_target[1:0] != 2'b00) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d     = bus.br_target;
            im_req_d = 1'b1;
            state_d  = FETCH;
          end
        end else if (bus.dec_ready) begin
          pc_d          = ADDR_W'(pc_q + 64'd4);
          instr_valid_d = 1'b0;
          if (bus.halt_req) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            im_req_d = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      HALT: begin
        im_req_d      = 1'b0;
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.im_req      = im_req_q;
  assign bus.im_addr     = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign fault           = fault_q;
endmodule
